// File: rtl/bitcount_sequencer.sv
// Multi-cycle bit counter: CPOP, CLZ and CTZ over a DATA_WIDTH operand.
// The operand is processed one byte per cycle, so latency is fixed at DATA_WIDTH/8 RUN cycles.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid, in_ready  - request handshake (accepted only in IDLE)
//   op, operand         - 00 CPOP, 01 CLZ, 10 CTZ, 11 reserved (gives 0); source value
//   out_valid, out_ready- result handshake (held in DONE until accepted)
//   result              - zero-extended count, forced to 0 while out_valid is low
//   busy                - high whenever the FSM is not idle
module bitcount_sequencer #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] operand,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  busy
);

  localparam int unsigned Beats = DATA_WIDTH / 8;
  localparam int unsigned CntW  = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastBeat = CntW'(Beats - 1);

  localparam logic [1:0] OpCpop = 2'b00;
  localparam logic [1:0] OpClz  = 2'b01;
  localparam logic [1:0] OpCtz  = 2'b10;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                state_q, state_d;
  logic [1:0]            op_q, op_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       acc_q, acc_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  found_q, found_d;

  logic [DATA_WIDTH-1:0] operand_rev;
  logic [7:0]            chunk;
  logic [3:0]            chunk_pop;
  logic [3:0]            chunk_tz;

  // CLZ is computed as CTZ of the bit-reversed operand.
  always_comb begin
    operand_rev = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      operand_rev[i] = operand[DATA_WIDTH-1-i];
    end
  end

  assign chunk = shift_q[7:0];

  always_comb begin
    chunk_pop = '0;
    for (int i = 0; i < 8; i++) begin
      chunk_pop = chunk_pop + {3'b000, chunk[i]};
    end
  end

  // Trailing-zero count of one byte; an all-zero byte yields 8.
  always_comb begin
    chunk_tz = 4'd8;
    for (int i = 7; i >= 0; i--) begin
      if (chunk[i]) chunk_tz = 4'(i);
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    shift_d = shift_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    found_d = found_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          state_d = StRun;
          op_d    = op;
          shift_d = (op == OpClz) ? operand_rev : operand;
          acc_d   = '0;
          cnt_d   = '0;
          found_d = 1'b0;
        end
      end
      StRun: begin
        shift_d = shift_q >> 8;
        cnt_d   = cnt_q + CntW'(1);
        case (op_q)
          OpCpop: acc_d = acc_q + CntW'(chunk_pop);
          OpClz, OpCtz: begin
            if (!found_q) begin
              acc_d   = acc_q + CntW'(chunk_tz);
              found_d = (chunk != 8'h00);
            end
          end
          default: acc_d = acc_q;
        endcase
        if (cnt_q == LastBeat) state_d = StDone;
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      op_q    <= 2'b00;
      shift_q <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      shift_q <= shift_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q != StIdle);
  assign result    = out_valid ? DATA_WIDTH'(acc_q) : '0;

endmodule

// File: tb/tb_bitcount_sequencer.sv
// Scoreboard bench for bitcount_sequencer (DATA_WIDTH = 32).
// Expected counts are pushed when a request is seen accepted and popped on each result handshake.
module tb_bitcount_sequencer;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] operand;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  int n_pop    = 0;
  logic [31:0] exp_q[$];

  bitcount_sequencer #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .operand   (operand),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  // Bit-serial reference, deliberately not byte-chunked.
  function automatic logic [31:0] ref_count(input logic [1:0] o, input logic [31:0] v);
    int n;
    n = 0;
    case (o)
      2'b00: for (int i = 0; i < 32; i++) n += int'(v[i]);
      2'b01: begin
        n = 32;
        for (int i = 0; i < 32; i++) if (v[i]) n = 31 - i;
      end
      2'b10: begin
        n = 32;
        for (int i = 31; i >= 0; i--) if (v[i]) n = i;
      end
      default: n = 0;
    endcase
    return 32'(n);
  endfunction

  // Monitor: inputs change just after posedge, so the negedge sees what the next edge acts on.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) exp_q.push_back(ref_count(op, operand));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_result", 32'(out_valid), 32'd0);
        else check_eq("sb_result", result, exp_q.pop_front());
        n_pop++;
      end
    end
    if (!out_valid) check_eq("result_zero_when_invalid", result, 32'd0);
  end

  // Issue one request from IDLE and check out_valid rises on the 4th edge after accept.
  task automatic do_op(input logic [1:0] o, input logic [31:0] v);
    int lat;
    in_valid = 1'b1;
    op       = o;
    operand  = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("latency", 32'(lat), 32'd4);
  endtask

  task automatic expect_idle_next;
    @(posedge clk); #1;
    check_eq("one_cycle_valid", 32'(out_valid), 32'd0);
    check_eq("ready_after", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int   guard;
    int   pop_base;
    logic late;
    logic rand_done;

    rst = 1'b1; in_valid = 1'b0; op = 2'b00; operand = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_in_ready", 32'(in_ready), 32'd1);
    check_eq("rst_out_valid", 32'(out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_result", result, 32'd0);
    rst = 1'b0;

    // First edge after reset release accepts.
    do_op(2'b00, 32'hF0F0_1234);
    check_eq("cpop_value", result, 32'd13);
    expect_idle_next();

    do_op(2'b01, 32'h0001_0000); expect_idle_next();
    do_op(2'b10, 32'h0001_0000); expect_idle_next();
    do_op(2'b10, 32'h8000_0000); expect_idle_next();
    do_op(2'b01, 32'h0);         expect_idle_next();
    do_op(2'b10, 32'h0);         expect_idle_next();
    do_op(2'b00, 32'h0);         expect_idle_next();
    do_op(2'b00, 32'hFFFF_FFFF); expect_idle_next();
    do_op(2'b01, 32'hFFFF_FFFF); expect_idle_next();
    do_op(2'b10, 32'hFFFF_FFFF); expect_idle_next();
    do_op(2'b11, 32'hDEAD_BEEF); expect_idle_next();

    // Backpressure in DONE with an ignored request pulse.
    out_ready = 1'b0;
    do_op(2'b00, 32'h0000_00FF);
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      op       = 2'b00;
      operand  = 32'hFFFF_FFFF;
      check_eq("bp_valid", 32'(out_valid), 32'd1);
      check_eq("bp_result", result, 32'd8);
      check_eq("bp_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check_eq("bp_ready_after", 32'(in_ready), 32'd1);
    do_op(2'b10, 32'h0000_0100); expect_idle_next();

    // Asynchronous reset mid-cycle during RUN beat 2.
    in_valid = 1'b1; op = 2'b00; operand = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check_eq("arst_busy", 32'(busy), 32'd0);
    check_eq("arst_out_valid", 32'(out_valid), 32'd0);
    check_eq("arst_result", result, 32'd0);
    check_eq("arst_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst = 1'b0;
    exp_q.delete();
    late = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (out_valid) late = 1'b1;
    end
    check_eq("no_late_valid", 32'(late), 32'd0);

    // Random stream with stalls on both sides.
    pop_base  = n_pop;
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 60; k++) begin
          int sel;
          repeat ($urandom_range(0, 2)) @(posedge clk);
          #1;
          sel      = $urandom_range(0, 5);
          op       = 2'($urandom_range(0, 3));
          operand  = (sel == 0) ? 32'h0 : (sel == 1) ? 32'hFFFF_FFFF :
                     (sel == 2) ? (32'h1 << $urandom_range(0, 31)) : $urandom;
          in_valid = 1'b1;
          guard    = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (!in_ready && guard < 500);
          if (guard >= 500) check_eq("accept_timeout", 32'(in_ready), 32'd1);
          @(posedge clk); #1;
          in_valid = 1'b0;
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 1000) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check_eq("drain_empty", 32'(exp_q.size()), 32'd0);
    check_eq("rand_result_count", 32'(n_pop - pop_base), 32'd60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
